// File: rtl/reg_file_pkg.sv
// Shared constants and types for the 32 x 32-bit CPU register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg_file_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_word_t;

    localparam reg_idx_t ZERO_REG = 5'd0;

endpackage : reg_file_pkg

// File: rtl/reg_file_32x32_if.sv
// Writeback/operand-fetch bundle of the register file: one write port, two read ports.
// Latency: n/a (wires only); reads are combinational, writes land one edge later.
// Backpressure: none; every write is accepted in the cycle it is presented.
// master = datapath side (drives we/waddr/wdata/raddr_*), slave = register file.
interface reg_file_32x32_if;
    import reg_file_pkg::*;

    logic      we;
    reg_idx_t  waddr;
    reg_word_t wdata;
    reg_idx_t  raddr_a;
    reg_idx_t  raddr_b;
    reg_word_t rdata_a;
    reg_word_t rdata_b;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b,
        input  rdata_a, rdata_b
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b,
        output rdata_a, rdata_b
    );

endinterface : reg_file_32x32_if

// File: rtl/reg_file_32x32_decoder.sv
// 5-to-32 one-hot write decoder.
// Latency: combinational.
// Backpressure: none.
// Ports: en (decode enable), idx (register index), sel (one-hot select, all zero if
// en is low or idx is not a clean binary value).
module decoder_5_32
    import reg_file_pkg::*;
(
    input  logic                en,
    input  reg_idx_t            idx,
    output logic [NUM_REGS-1:0] sel
);

    // Equality against each index: an unknown idx compares as X, which the
    // if treats as false, so a non-binary index selects nothing.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (en && (idx == reg_idx_t'(i))) begin
                sel[i] = 1'b1;
            end
        end
    end

endmodule : decoder_5_32

// File: rtl/reg_file_32x32_mux.sv
// 32-way, 32-bit read multiplexer for one register-file read port.
// Latency: combinational.
// Backpressure: none.
// Ports: sel (register index), din (all register words), dout (selected word).
module mux_32x32
    import reg_file_pkg::*;
(
    input  reg_idx_t  sel,
    input  reg_word_t din [NUM_REGS],
    output reg_word_t dout
);

    assign dout = din[sel];

endmodule : mux_32x32

// File: rtl/reg_file_32x32.sv
// CPU general-purpose register file, 32 x 32 bits, register 0 hardwired to zero.
// Latency: write 1 cycle, reads combinational (0 cycles).
// Backpressure: none; writes are always accepted.
// Ports: clk, rst_n (async active-low clear of all registers), bus (slave modport:
// we/waddr/wdata write port, raddr_a/raddr_b -> rdata_a/rdata_b read ports).
// Build option: define REG_FILE_WRITE_BYPASS_EN to forward wdata to a read port
// reading the register being written in the same cycle (write-first).
module reg_file_32x32
    import reg_file_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    reg_file_32x32_if.slave   bus
);

    reg_word_t           r_regs [1:NUM_REGS-1];
    reg_word_t           w_regs [NUM_REGS];
    logic [NUM_REGS-1:0] w_sel;
    logic [NUM_REGS-1:0] w_wr_en;
    reg_word_t           w_mux_a;
    reg_word_t           w_mux_b;

    decoder_5_32 u_wr_dec (
        .en  (bus.we),
        .idx (bus.waddr),
        .sel (w_sel)
    );

    // Bit 0 is never enabled: register 0 has no storage at all.
    assign w_wr_en = w_sel & {31'h7FFF_FFFF, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_wr_en[i]) begin
                    r_regs[i] <= bus.wdata;
                end
            end
        end
    end

    assign w_regs[ZERO_REG] = '0;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_rd_view
        assign w_regs[g] = r_regs[g];
    end

    mux_32x32 u_rd_mux_a (
        .sel  (bus.raddr_a),
        .din  (w_regs),
        .dout (w_mux_a)
    );

    mux_32x32 u_rd_mux_b (
        .sel  (bus.raddr_b),
        .din  (w_regs),
        .dout (w_mux_b)
    );

`ifdef REG_FILE_WRITE_BYPASS_EN
    // w_wr_en already excludes index 0 and non-binary write indexes, so
    // looking it up by the read index is exactly "writing the register I read".
    assign bus.rdata_a = w_wr_en[bus.raddr_a] ? bus.wdata : w_mux_a;
    assign bus.rdata_b = w_wr_en[bus.raddr_b] ? bus.wdata : w_mux_b;
`else
    assign bus.rdata_a = w_mux_a;
    assign bus.rdata_b = w_mux_b;
`endif

endmodule : reg_file_32x32

// File: tb/tb_reg_file_32x32.sv
// Scoreboard bench for reg_file_32x32: stimulus pushes expected read data,
// a monitor process samples both read ports and compares.
// Latency/backpressure: n/a (testbench).
module tb_reg_file_32x32;
    import reg_file_pkg::*;

    logic clk;
    logic rst_n;

    reg_file_32x32_if bus ();

    reg_file_32x32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        reg_word_t a;
        reg_word_t b;
    } exp_t;

    exp_t  exp_q  [$];
    string name_q [$];
    event  chk_ev;
    int    checks = 0;
    int    errors = 0;

    // Monitor: the read ports are combinational, so "output present" is the
    // stimulus signalling that new read indexes have been applied.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(chk_ev);
            #1;
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (bus.rdata_a !== e.a) begin
                    errors++;
                    $display("FAIL %s port A: got %h expected %h", n, bus.rdata_a, e.a);
                end
                checks++;
                if (bus.rdata_b !== e.b) begin
                    errors++;
                    $display("FAIL %s port B: got %h expected %h", n, bus.rdata_b, e.b);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input reg_idx_t ra, input reg_idx_t rb,
                         input reg_word_t ea, input reg_word_t eb, input string nm);
        bus.raddr_a = ra;
        bus.raddr_b = rb;
        exp_q.push_back('{a: ea, b: eb});
        name_q.push_back(nm);
        -> chk_ev;
        #2;
    endtask

    task automatic check(input reg_idx_t ra, input reg_idx_t rb,
                         input reg_word_t ea, input reg_word_t eb, input string nm);
        @(negedge clk);
        issue(ra, rb, ea, eb, nm);
    endtask

    task automatic wr(input reg_idx_t a, input reg_word_t d);
        @(negedge clk);
        bus.we    = 1'b1;
        bus.waddr = a;
        bus.wdata = d;
        @(posedge clk);
        #1;
        bus.we    = 1'b0;
    endtask

    initial begin
        reg_word_t rdw_exp;

        rst_n       = 1'b0;
        bus.we      = 1'b0;
        bus.waddr   = '0;
        bus.wdata   = '0;
        bus.raddr_a = '0;
        bus.raddr_b = '0;

        // Reset state: every register reads zero on both ports.
        repeat (2) @(negedge clk);
        for (int i = 0; i < NUM_REGS; i++) begin
            check(reg_idx_t'(i), reg_idx_t'(31 - i), '0, '0, "reset_sweep");
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Unknown write index with we=1 must not disturb anything.
        @(negedge clk);
        bus.we    = 1'b1;
        bus.waddr = 'x;
        bus.wdata = '0;
        @(posedge clk);
        #1;
        bus.we    = 1'b0;
        bus.waddr = '0;
        check(5'd1, 5'd30, '0, '0, "x_waddr");

        // Walk writes: reg[i] = 3*i.
        for (int i = 1; i < NUM_REGS; i++) begin
            wr(reg_idx_t'(i), reg_word_t'(i * 3));
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            check(reg_idx_t'(i), reg_idx_t'(31 - i),
                  reg_word_t'(i * 3), reg_word_t'((31 - i) * 3), "walk_sweep");
        end

        // Writes to register 0 are discarded.
        wr(5'd0, 32'hDEAD_BEEF);
        check(5'd0, 5'd0, '0, '0, "zero_reg");
        repeat (3) @(negedge clk);
        check(5'd0, 5'd1, '0, 32'd3, "zero_reg_later");

        // we=0 leaves reg 5 alone.
        @(negedge clk);
        bus.we    = 1'b0;
        bus.waddr = 5'd5;
        bus.wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        check(5'd5, 5'd5, 32'd15, 32'd15, "write_disable");

        // Read-during-write on reg 7 (currently 21).
`ifdef REG_FILE_WRITE_BYPASS_EN
        rdw_exp = 32'h1234_5678;
`else
        rdw_exp = 32'd21;
`endif
        @(negedge clk);
        bus.we    = 1'b1;
        bus.waddr = 5'd7;
        bus.wdata = 32'h1234_5678;
        issue(5'd7, 5'd8, rdw_exp, 32'd24, "rdw_before_edge");
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        check(5'd7, 5'd7, 32'h1234_5678, 32'h1234_5678, "rdw_after_edge");

        // Both ports on the same index.
        check(5'd12, 5'd12, 32'd36, 32'd36, "dual_same_idx");

        // Reset asserted mid-cycle alongside a write: clears immediately, write lost.
        @(negedge clk);
        bus.we    = 1'b1;
        bus.waddr = 5'd3;
        bus.wdata = 32'h0000_CAFE;
        #1;
        rst_n = 1'b0;
        issue(5'd12, 5'd31, '0, '0, "reset_immediate");
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            check(reg_idx_t'(i), reg_idx_t'(31 - i), '0, '0, "reset_mid_sweep");
        end
        @(negedge clk);
        rst_n = 1'b1;
        check(5'd3, 5'd7, '0, '0, "after_reset_release");

        // Post-reset write still works.
        wr(5'd9, 32'hA5A5_0009);
        check(5'd9, 5'd10, 32'hA5A5_0009, '0, "post_reset_write");

        // Drain the scoreboard (bounded).
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
            #1;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_file_32x32
